analog_io_seq_ctrl: RTL

//  Wishbone-programmable successor to the fixed analog pad tie-off control, for N_CH analog pads.

---
 rtl/analog_io_seq_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/analog_io_seq_ctrl.sv
// Wishbone-programmable analog pad safe-state control with a bias enable
// sequencer (OFF -> UP -> ACTIVE -> DN) and a programmable settle time.
module analog_io_seq_ctrl #(
    parameter int          N_CH      = 6,
    parameter logic [31:0] BASE_ADDR = 32'h3000_0100,
    parameter int          SETTLE_W  = 16
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_stb_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic [31:0]     wbs_dat_o,
    output logic            wbs_ack_o,
    output logic [N_CH-1:0] io_oeb,
    output logic [N_CH-1:0] io_out,
    output logic            bias_en_o,
    output logic            irq_o
);

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        UP     = 2'd1,
        ACTIVE = 2'd2,
        DN     = 2'd3
    } state_t;

    localparam logic [31:0] SETTLE_RST = 32'h0000_00FF;

    state_t              state;
    logic [SETTLE_W-1:0] cnt;
    logic [SETTLE_W-1:0] settle;
    logic [N_CH-1:0]     drive;
    logic [N_CH-1:0]     outv;
    logic                en;
    logic                irq_en;
    logic                done;

    logic        hit;
    logic        fire;
    logic        wr;
    logic        w1c;
    logic        busy;
    logic [5:0]  off;
    logic [31:0] rd;
    logic [31:0] wdata;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] d,
        input logic [3:0]  sel
    );
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) r[8*b +: 8] = d[8*b +: 8];
        end
        return r;
    endfunction

    assign hit  = wbs_cyc_i & wbs_stb_i
                & (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign fire = hit & ~wbs_ack_o;
    assign wr   = fire & wbs_we_i;
    assign off  = wbs_adr_i[7:2];
    assign busy = (state == UP) | (state == DN);
    assign w1c  = wr & (off == 6'h01) & wbs_sel_i[0] & wbs_dat_i[4];

    always_comb begin
        rd = '0;
        case (off)
            6'h00:   rd = {30'd0, irq_en, en};
            6'h01:   rd = {27'd0, done, busy, 1'b0, state};
            6'h02:   rd = 32'(settle);
            6'h03:   rd = 32'(drive);
            6'h04:   rd = 32'(outv);
            default: rd = '0;
        endcase
    end

    // Byte-lane merge onto the current value keeps unselected bytes intact.
    assign wdata = merge(rd, wbs_dat_i, wbs_sel_i);

    logic unused_ok;
    assign unused_ok = ^{wbs_adr_i[1:0], wdata};

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= '0;
            en        <= 1'b0;
            irq_en    <= 1'b0;
            settle    <= SETTLE_RST[SETTLE_W-1:0];
            drive     <= '0;
            outv      <= '0;
        end else begin
            wbs_ack_o <= fire;
            wbs_dat_o <= (fire & ~wbs_we_i) ? rd : '0;
            if (wr) begin
                case (off)
                    6'h00: {irq_en, en} <= wdata[1:0];
                    6'h02: settle       <= wdata[SETTLE_W-1:0];
                    6'h03: drive        <= wdata[N_CH-1:0];
                    6'h04: outv         <= wdata[N_CH-1:0];
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_i) begin
            state     <= OFF;
            cnt       <= '0;
            done      <= 1'b0;
            bias_en_o <= 1'b0;
            io_oeb    <= '1;
            io_out    <= '0;
            irq_o     <= 1'b0;
        end else begin
            irq_o  <= done & irq_en;
            io_oeb <= '1;
            io_out <= '0;
            // A DONE set below overrides this clear in the same cycle.
            if (w1c) done <= 1'b0;
            unique case (state)
                OFF: begin
                    if (en) begin
                        state     <= UP;
                        cnt       <= settle;
                        bias_en_o <= 1'b1;
                    end
                end
                UP: begin
                    if (!en) begin
                        state <= DN;
                        cnt   <= settle;
                    end else if (cnt == '0) begin
                        state  <= ACTIVE;
                        done   <= 1'b1;
                        io_oeb <= ~drive;
                        io_out <= drive & outv;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACTIVE: begin
                    if (!en) begin
                        state <= DN;
                        cnt   <= settle;
                    end else begin
                        io_oeb <= ~drive;
                        io_out <= drive & outv;
                    end
                end
                DN: begin
                    if (en) begin
                        state <= UP;
                        cnt   <= settle;
                    end else if (cnt == '0) begin
                        state     <= OFF;
                        done      <= 1'b1;
                        bias_en_o <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
